// File: rtl/rr_grant_arbiter8.sv
// rtl/rr_grant_arbiter8.sv - round-robin arbiter for 8 requesters with grant hold timeout
// Registered one-hot grant plus encoded index; rotating priority pointer follows the last grant.
module rr_grant_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic             found;
    logic [2:0]       pick;

    // First set request bit scanning upward from ptr and wrapping past 7.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[ptr_q + 3'(i)]) begin
                found = 1'b1;
                pick  = ptr_q + 3'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    gnt_d    = 8'b1 << pick;
                    gnt_id_d = pick;
                    valid_d  = 1'b1;
                    hold_d   = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
                // A dropped request takes precedence, so a coincident timeout is not flagged.
                if (!req[gnt_id_q] || (MAX_HOLD != 0 && hold_q == HOLD_LAST)) begin
                    gnt_d     = 8'd0;
                    valid_d   = 1'b0;
                    ptr_d     = gnt_id_q + 3'd1;
                    state_d   = RELEASE;
                    timeout_d = req[gnt_id_q];
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            hold_q    <= '0;
            gnt_q     <= 8'd0;
            gnt_id_q  <= 3'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// tb/tb_rr_grant_arbiter8.sv - directed self-checking bench for rr_grant_arbiter8
module tb_rr_grant_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_grant_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; req = 8'd0;
        tick(); tick();
        n_cmp++; if (gnt !== 8'd0) begin n_fail++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        n_cmp++; if (gnt_id !== 3'd0) begin n_fail++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
        n_cmp++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req = 8'h04; en = 1'b1;
        tick();
        n_cmp++; if (gnt !== 8'h04) begin n_fail++; $display("FAIL single_gnt: got %h want 04", gnt); end
        n_cmp++; if (gnt_id !== 3'd2) begin n_fail++; $display("FAIL single_id: got %0d want 2", gnt_id); end
        n_cmp++; if (gnt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", gnt_valid); end
        tick();
        n_cmp++; if (gnt !== 8'h04) begin n_fail++; $display("FAIL single_hold: got %h want 04", gnt); end
        req = 8'h00;
        tick();
        n_cmp++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: got %h/%b want 00/0", gnt, gnt_valid); end
        n_cmp++; if (gnt_id !== 3'd2) begin n_fail++; $display("FAIL single_id_kept: got %0d want 2", gnt_id); end
        req = 8'h0C;
        tick();
        n_cmp++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL single_dead_cycle: got %h want 00", gnt); end
        tick();
        n_cmp++; if (gnt !== 8'h08 || gnt_id !== 3'd3) begin n_fail++; $display("FAIL single_ptr3: got %h/%0d want 08/3", gnt, gnt_id); end
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_rotation();
        logic [7:0] exp_g;
        int e;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req = 8'hFF; en = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) begin
            e = k % 8;
            exp_g = 8'b1 << e;
            n_cmp++; if (gnt !== exp_g || gnt_id !== 3'(e)) begin n_fail++; $display("FAIL rotation_grant%0d: got %h/%0d want %h/%0d", k, gnt, gnt_id, exp_g, e); end
            tick();
            n_cmp++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rotation_hold%0d: got %h want %h", k, gnt, exp_g); end
            req[e] = 1'b0;
            tick();
            n_cmp++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL rotation_release%0d: got %b want 0", k, gnt_valid); end
            req[e] = 1'b1;
            tick(); tick();
        end
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_wrap();
        req = 8'h40; en = 1'b1;
        tick();
        n_cmp++; if (gnt !== 8'h40 || gnt_id !== 3'd6) begin n_fail++; $display("FAIL wrap_grant6: got %h/%0d want 40/6", gnt, gnt_id); end
        req = 8'h00;
        tick(); tick();
        req = 8'h81;
        tick();
        n_cmp++; if (gnt !== 8'h80 || gnt_id !== 3'd7) begin n_fail++; $display("FAIL wrap_grant7: got %h/%0d want 80/7", gnt, gnt_id); end
        req = 8'h01;
        tick(); tick(); tick();
        n_cmp++; if (gnt !== 8'h01 || gnt_id !== 3'd0) begin n_fail++; $display("FAIL wrap_grant0: got %h/%0d want 01/0", gnt, gnt_id); end
        req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_timeout();
        int cnt = 0;
        bit early_to = 1'b0;
        req = 8'h10; en = 1'b1;
        tick();
        if (gnt === 8'h10) cnt = 1;
        for (int i = 0; i < 40 && gnt_valid === 1'b1; i++) begin
            if (timeout !== 1'b0) early_to = 1'b1;
            tick();
            if (gnt_valid === 1'b1) cnt++;
        end
        n_cmp++; if (cnt != 16) begin n_fail++; $display("FAIL timeout_hold_len: got %0d want 16", cnt); end
        n_cmp++; if (early_to !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0", early_to); end
        n_cmp++; if (timeout !== 1'b1 || gnt !== 8'h00) begin n_fail++; $display("FAIL timeout_pulse: got %b/%h want 1/00", timeout, gnt); end
        tick();
        n_cmp++; if (timeout !== 1'b0 || gnt !== 8'h00) begin n_fail++; $display("FAIL timeout_dead: got %b/%h want 0/00", timeout, gnt); end
        tick();
        n_cmp++; if (gnt !== 8'h10 || gnt_id !== 3'd4) begin n_fail++; $display("FAIL timeout_regrant: got %h/%0d want 10/4", gnt, gnt_id); end
        req = 8'h00;
        tick();
        n_cmp++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_normal_release: got %b want 0", timeout); end
        tick();
    endtask

    task automatic test_enable();
        en = 1'b0; req = 8'h20;
        tick(); tick();
        n_cmp++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin n_fail++; $display("FAIL enable_off: got %h/%b want 00/0", gnt, gnt_valid); end
        en = 1'b1;
        tick();
        n_cmp++; if (gnt !== 8'h20 || gnt_id !== 3'd5) begin n_fail++; $display("FAIL enable_on: got %h/%0d want 20/5", gnt, gnt_id); end
        en = 1'b0; req = 8'h21;
        tick(); tick(); tick();
        n_cmp++; if (gnt !== 8'h20 || gnt_valid !== 1'b1) begin n_fail++; $display("FAIL enable_no_revoke: got %h/%b want 20/1", gnt, gnt_valid); end
        req = 8'h00;
        tick();
        n_cmp++; if (gnt !== 8'h00) begin n_fail++; $display("FAIL enable_release: got %h want 00", gnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        en = 1'b1; req = 8'h02;
        tick();
        n_cmp++; if (gnt !== 8'h02 || gnt_id !== 3'd1) begin n_fail++; $display("FAIL mid_pre_grant: got %h/%0d want 02/1", gnt, gnt_id); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== 8'h00 || gnt_id !== 3'd0 || gnt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got %h/%0d/%b want 00/0/0", gnt, gnt_id, gnt_valid); end
        req = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
